// File: rtl/l2_line_server.sv
// l2_line_server: in-order, multi-outstanding L2 line-fill responder.
// Requests are queued with a snapshot of the backing-array line taken at accept.
// Each response is released after a fixed miss penalty, counted in run_i cycles.
module l2_line_server #(
  parameter int LINE_BITS     = 256,
  parameter int ADDR_BITS     = 32,
  parameter int OFFSET_BITS   = 5,
  parameter int INDEX_BITS    = 7,
  parameter int TAG_BITS      = ADDR_BITS - INDEX_BITS - OFFSET_BITS,
  parameter int MISS_PENALTY  = 2,
  parameter int QUEUE_DEPTH   = 4,
  parameter int MEM_LINES_LOG = 10
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               run_i,
  input  logic                               flush_i,
  input  logic                               req_valid_i,
  input  logic [ADDR_BITS-1:0]               req_addr_i,
  output logic                               req_ready_o,
  output logic                               resp_valid_o,
  input  logic                               resp_ready_i,
  output logic [LINE_BITS-1:0]               resp_data_o,
  output logic [TAG_BITS-1:0]                resp_tag_o,
  output logic [INDEX_BITS-1:0]              resp_index_o,
  input  logic                               wr_en_i,
  input  logic [MEM_LINES_LOG-1:0]           wr_line_i,
  input  logic [LINE_BITS-1:0]               wr_data_i,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   outstanding_o
);

  localparam int CNT_BITS  = $clog2(MISS_PENALTY + 1);
  localparam int PTR_BITS  = $clog2(QUEUE_DEPTH);
  localparam int OCC_BITS  = $clog2(QUEUE_DEPTH + 1);
  localparam int LA_BITS   = ADDR_BITS - OFFSET_BITS;  // line address: offset stripped
  localparam int MEM_LINES = 1 << MEM_LINES_LOG;

  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(MISS_PENALTY - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
  localparam logic [PTR_BITS-1:0] PTR_ONE  = PTR_BITS'(1);
  localparam logic [OCC_BITS-1:0] OCC_ONE  = OCC_BITS'(1);
  localparam logic [OCC_BITS-1:0] OCC_FULL = OCC_BITS'(QUEUE_DEPTH);

  // Backing array (never reset; the environment preloads it)
  logic [LINE_BITS-1:0] mem_q [MEM_LINES];

  // Queue entries
  logic [LA_BITS-1:0]   addr_q [QUEUE_DEPTH];
  logic [LA_BITS-1:0]   addr_d [QUEUE_DEPTH];
  logic [LINE_BITS-1:0] data_q [QUEUE_DEPTH];
  logic [LINE_BITS-1:0] data_d [QUEUE_DEPTH];
  logic [CNT_BITS-1:0]  cnt_q  [QUEUE_DEPTH];
  logic [CNT_BITS-1:0]  cnt_d  [QUEUE_DEPTH];

  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_BITS-1:0] occ_q, occ_d;

  logic                     accept_s;
  logic                     pop_s;
  logic                     flush_s;
  logic                     head_ready_s;
  logic [MEM_LINES_LOG-1:0] rd_line_s;
  logic [LINE_BITS-1:0]     rd_data_s;
  logic                     unused_offset_s;

  // Byte-offset bits select nothing: a request always returns the whole line.
  assign unused_offset_s = ^req_addr_i[OFFSET_BITS-1:0];

  // Upper address bits alias onto the array, so addresses wrap modulo its size.
  assign rd_line_s = req_addr_i[OFFSET_BITS +: MEM_LINES_LOG];
  assign rd_data_s = mem_q[rd_line_s];

  // Handshake qualification; flush suppresses transfers but not the valid/ready view
  always_comb begin
    head_ready_s = (occ_q != '0) && (cnt_q[rd_ptr_q] == '0);
    req_ready_o  = run_i & (occ_q < OCC_FULL);
    resp_valid_o = run_i & head_ready_s;
    flush_s      = run_i & flush_i;
    accept_s     = run_i & req_valid_i & req_ready_o & ~flush_i;
    pop_s        = resp_valid_o & resp_ready_i & ~flush_i;
  end

  // Queue next-state: flush, countdown, accept into tail, pop from head
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush_s) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        cnt_d[i] = '0;
      end
    end else begin
      // All live entries age together, including those behind a stalled head.
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (run_i && (cnt_q[i] != '0)) begin
          cnt_d[i] = cnt_q[i] - CNT_ONE;
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end
      // Snapshot uses the pre-edge array contents, so a same-cycle write is not seen.
      if (accept_s) begin
        addr_d[wr_ptr_q] = req_addr_i[ADDR_BITS-1:OFFSET_BITS];
        data_d[wr_ptr_q] = rd_data_s;
        cnt_d[wr_ptr_q]  = CNT_LOAD;
        wr_ptr_d         = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({accept_s, pop_s})
        2'b10:   occ_d = occ_q + OCC_ONE;
        2'b01:   occ_d = occ_q - OCC_ONE;
        default: occ_d = occ_q;
      endcase
    end
  end

  // Queue state register; reset discards every in-flight request
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  // Backing-array write port; active regardless of run_i
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_line_i] <= wr_data_i;
    end
  end

  // Head entry drives the response; it cannot change until popped or flushed.
  assign resp_data_o   = data_q[rd_ptr_q];
  assign resp_tag_o    = addr_q[rd_ptr_q][LA_BITS-1 -: TAG_BITS];
  assign resp_index_o  = addr_q[rd_ptr_q][0 +: INDEX_BITS];
  assign outstanding_o = occ_q;

endmodule

// File: tb/tb_l2_line_server.sv
// Directed bench for l2_line_server: a MISS_PENALTY=2 instance plus a
// MISS_PENALTY=1 instance sharing all inputs.
module tb_l2_line_server;

  logic         clk;
  logic         reset;
  logic         run;
  logic         flush;
  logic         req_valid;
  logic [31:0]  req_addr;
  logic         resp_ready;
  logic         wr_en;
  logic [9:0]   wr_line;
  logic [255:0] wr_data;

  logic         req_ready0, resp_valid0, req_ready1, resp_valid1;
  logic [255:0] resp_data0, resp_data1;
  logic [19:0]  resp_tag0, resp_tag1;
  logic [6:0]   resp_index0, resp_index1;
  logic [2:0]   outstanding0, outstanding1;

  int checks   = 0;
  int failures = 0;

  localparam logic [255:0] LINE_A5  = {32{8'hA5}};
  localparam logic [255:0] LINE_NEW = {8{32'hDEAD_BEEF}};

  l2_line_server #(.MISS_PENALTY(2)) u_dut0 (
    .clk(clk), .reset(reset), .run_i(run), .flush_i(flush),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(req_ready0),
    .resp_valid_o(resp_valid0), .resp_ready_i(resp_ready), .resp_data_o(resp_data0),
    .resp_tag_o(resp_tag0), .resp_index_o(resp_index0),
    .wr_en_i(wr_en), .wr_line_i(wr_line), .wr_data_i(wr_data),
    .outstanding_o(outstanding0)
  );

  l2_line_server #(.MISS_PENALTY(1)) u_dut1 (
    .clk(clk), .reset(reset), .run_i(run), .flush_i(flush),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(req_ready1),
    .resp_valid_o(resp_valid1), .resp_ready_i(resp_ready), .resp_data_o(resp_data1),
    .resp_tag_o(resp_tag1), .resp_index_o(resp_index1),
    .wr_en_i(wr_en), .wr_line_i(wr_line), .wr_data_i(wr_data),
    .outstanding_o(outstanding1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Preloaded contents: line 3 is all A5, every other line a numbered pattern.
  function automatic logic [255:0] exp_line(input int k);
    logic [31:0] w;
    w = 32'h5A00_0000 + 32'(k);
    if (k == 3) return LINE_A5;
    else return {8{w}};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; flush = 1'b0; req_valid = 1'b0; req_addr = 32'h0;
    resp_ready = 1'b0; wr_en = 1'b0; wr_line = 10'h0; wr_data = 256'h0;
    tick(); tick();

    // Reset state
    #1;
    chk("rst_valid", resp_valid0, 1'b0);
    chk("rst_ready", req_ready0, 1'b1);
    chk("rst_data", resp_data0, 256'h0);
    chk("rst_tag", resp_tag0, 20'h0);
    chk("rst_index", resp_index0, 7'h0);
    chk("rst_outstanding", outstanding0, 3'd0);
    chk("rst_outstanding_mp1", outstanding1, 3'd0);
    run = 1'b0;
    #1;
    chk("rst_ready_run_low", req_ready0, 1'b0);
    run = 1'b1;
    reset = 1'b0;
    tick();

    // Preload lines 0..7
    for (int k = 0; k < 8; k++) begin
      wr_en = 1'b1; wr_line = 10'(k); wr_data = exp_line(k);
      tick();
    end
    wr_en = 1'b0;
    tick();

    // Single request to line 3
    resp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h0000_0060;
    #1;
    chk("single_ready", req_ready0, 1'b1);
    tick();
    req_valid = 1'b0;
    #1;
    chk("single_c1_valid", resp_valid0, 1'b0);
    chk("single_c1_outstanding", outstanding0, 3'd1);
    chk("mp1_valid", resp_valid1, 1'b1);
    chk("mp1_data", resp_data1, LINE_A5);
    chk("mp1_tag", resp_tag1, 20'h0);
    chk("mp1_index", resp_index1, 7'd3);
    tick();
    #1;
    chk("single_c2_valid", resp_valid0, 1'b1);
    chk("single_data", resp_data0, LINE_A5);
    chk("single_tag", resp_tag0, 20'h0);
    chk("single_index", resp_index0, 7'd3);
    chk("mp1_outstanding_after", outstanding1, 3'd0);
    tick();
    #1;
    chk("single_valid_after", resp_valid0, 1'b0);
    chk("single_outstanding_after", outstanding0, 3'd0);
    tick();

    // Back-to-back burst of 6 requests with consumer always ready
    for (int t = 0; t < 8; t++) begin
      req_valid = (t < 6);
      req_addr  = 32'(t * 32);
      #1;
      if (t < 6) chk("burst_ready", req_ready0, 1'b1);
      if (t >= 2) begin
        chk("burst_valid", resp_valid0, 1'b1);
        chk("burst_data", resp_data0, exp_line(t - 2));
        chk("burst_index", resp_index0, 7'(t - 2));
      end else begin
        chk("burst_early_valid", resp_valid0, 1'b0);
      end
      tick();
    end
    #1;
    chk("burst_drained", outstanding0, 3'd0);
    tick();

    // Full queue under backpressure
    resp_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      req_valid = 1'b1; req_addr = 32'(t * 32);
      #1;
      chk("full_fill_ready", req_ready0, 1'b1);
      tick();
    end
    req_addr = 32'h0000_0080;
    #1;
    chk("full_ready_low", req_ready0, 1'b0);
    chk("full_outstanding", outstanding0, 3'd4);
    chk("full_head_valid", resp_valid0, 1'b1);
    chk("full_head_data", resp_data0, exp_line(0));
    tick();
    #1;
    chk("full_hold_ready", req_ready0, 1'b0);
    chk("full_hold_data", resp_data0, exp_line(0));
    chk("full_hold_outstanding", outstanding0, 3'd4);
    resp_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      #1;
      chk("drain_valid", resp_valid0, 1'b1);
      chk("drain_data", resp_data0, exp_line(t));
      if (t == 0) chk("drain_no_passthrough", req_ready0, 1'b0);
      if (t == 1) chk("drain_accept_ready", req_ready0, 1'b1);
      tick();
      if (t == 1) req_valid = 1'b0;
    end
    #1;
    chk("drain_empty", outstanding0, 3'd0);
    chk("drain_valid_off", resp_valid0, 1'b0);
    tick();

    // run_i low for 3 cycles mid-countdown delays the response by 3
    req_valid = 1'b1; req_addr = 32'h0000_0020;
    tick();
    req_valid = 1'b0; run = 1'b0;
    for (int t = 0; t < 3; t++) begin
      #1;
      chk("frozen_valid", resp_valid0, 1'b0);
      chk("frozen_ready", req_ready0, 1'b0);
      tick();
    end
    run = 1'b1;
    #1;
    chk("thaw_c1_valid", resp_valid0, 1'b0);
    tick();
    #1;
    chk("thaw_c2_valid", resp_valid0, 1'b1);
    chk("thaw_data", resp_data0, exp_line(1));
    tick();
    #1;
    chk("thaw_outstanding", outstanding0, 3'd0);
    tick();

    // Flush with 3 queued
    resp_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      req_valid = 1'b1; req_addr = 32'(t * 32);
      tick();
    end
    req_valid = 1'b0; flush = 1'b1;
    #1;
    chk("flush_pre_outstanding", outstanding0, 3'd3);
    tick();
    flush = 1'b0; resp_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      #1;
      chk("flush_valid", resp_valid0, 1'b0);
      chk("flush_outstanding", outstanding0, 3'd0);
      tick();
    end

    // Reset with 2 queued
    resp_ready = 1'b0;
    for (int t = 4; t < 6; t++) begin
      req_valid = 1'b1; req_addr = 32'(t * 32);
      tick();
    end
    req_valid = 1'b0;
    #1;
    chk("prereset_data", resp_data0, exp_line(4));
    reset = 1'b1;
    tick();
    reset = 1'b0; resp_ready = 1'b1;
    #1;
    chk("midreset_valid", resp_valid0, 1'b0);
    chk("midreset_data", resp_data0, 256'h0);
    chk("midreset_tag", resp_tag0, 20'h0);
    chk("midreset_index", resp_index0, 7'h0);
    chk("midreset_outstanding", outstanding0, 3'd0);
    tick();
    for (int t = 0; t < 3; t++) begin
      #1;
      chk("postreset_valid", resp_valid0, 1'b0);
      tick();
    end

    // Same-cycle write and accept to line 7, then an accept that sees the new data
    wr_en = 1'b1; wr_line = 10'd7; wr_data = LINE_NEW;
    req_valid = 1'b1; req_addr = 32'h0000_00E0;
    tick();
    wr_en = 1'b0;
    tick();
    req_valid = 1'b0;
    #1;
    chk("rw_old_valid", resp_valid0, 1'b1);
    chk("rw_old_data", resp_data0, exp_line(7));
    tick();
    #1;
    chk("rw_new_valid", resp_valid0, 1'b1);
    chk("rw_new_data", resp_data0, LINE_NEW);
    tick();

    // Aliased address reads line 2, tag keeps the full address
    req_valid = 1'b1; req_addr = 32'h0000_8040;
    tick();
    req_valid = 1'b0;
    tick();
    #1;
    chk("alias_valid", resp_valid0, 1'b1);
    chk("alias_data", resp_data0, exp_line(2));
    chk("alias_tag", resp_tag0, 20'h00008);
    chk("alias_index", resp_index0, 7'd2);
    tick();
    #1;
    chk("alias_outstanding", outstanding0, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_line_server.md
# l2_line_server

Parametrised, multi-outstanding L2 line-fill responder for the instruction-fetch side of the simulation environment. It accepts line-read requests through a valid/ready handshake and queues up to `QUEUE_DEPTH` of them. Each request is returned in order, after a fixed `MISS_PENALTY`, with the full cache line plus its tag and index. Line data comes from an internal backing array that the bench preloads through a write port. It sits between the L1 I-cache miss interface and the bench.

## Interface
- `LINE_BITS`, 256: line width in bits.
- `ADDR_BITS`, 32: request address width.
- `OFFSET_BITS`, 5: byte-offset bits within a line, log2 of line bytes.
- `INDEX_BITS`, 7: L1 index width.
- `TAG_BITS`, `ADDR_BITS-INDEX_BITS-OFFSET_BITS`: L1 tag width.
- `MISS_PENALTY`, 2: cycles from request to earliest response, ≥1.
- `QUEUE_DEPTH`, 4: outstanding-request capacity, power of 2, ≥2.
- `MEM_LINES_LOG`, 10: log2 of backing-array line count.
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `run_i`, in, 1: global advance enable; low freezes the block.
- `flush_i`, in, 1: drop all queued requests.
- `req_valid_i`, in, 1: request present.
- `req_addr_i`, in, `ADDR_BITS`: request byte address; offset bits ignored.
- `req_ready_o`, out, 1: request can be accepted.
- `resp_valid_o`, out, 1: head response valid.
- `resp_ready_i`, in, 1: consumer takes the response.
- `resp_data_o`, out, `LINE_BITS`: line data.
- `resp_tag_o`, out, `TAG_BITS`: address bits `[ADDR_BITS-1 : INDEX_BITS+OFFSET_BITS]`.
- `resp_index_o`, out, `INDEX_BITS`: address bits `[INDEX_BITS+OFFSET_BITS-1 : OFFSET_BITS]`.
- `wr_en_i`, in, 1: backing-array write.
- `wr_line_i`, in, `MEM_LINES_LOG`: write line number.
- `wr_data_i`, in, `LINE_BITS`: write data.
- `outstanding_o`, out, `$clog2(QUEUE_DEPTH+1)`: current queue occupancy.

## Operation
- **Queue.** Circular FIFO with read and write pointers plus an occupancy counter. Each entry holds the address, the line data snapshot and a countdown of `$clog2(MISS_PENALTY+1)` bits.
- **Accept.** Occurs when `run_i & req_valid_i & req_ready_o & ~flush_i`.
  - `req_ready_o = run_i & (occupancy < QUEUE_DEPTH)`. There is no pass-through when full, even if a pop happens in the same cycle.
- **Array read.** Uses line `req_addr_i[OFFSET_BITS +: MEM_LINES_LOG]`. Higher address bits alias, so addresses wrap modulo array size.
  - The line data is captured into the entry at accept.
  - If a write hits the same line in the same cycle, the entry captures the pre-write (old) data.
- **Countdown.** Loaded with `MISS_PENALTY-1` at accept. Every entry with a nonzero count decrements in each `run_i` cycle.
- **Response.**
  - `resp_valid_o = run_i & (occupancy ≠ 0) & (head count == 0)`.
  - Pop occurs when `resp_valid_o & resp_ready_i`.
  - `resp_data_o`, `resp_tag_o` and `resp_index_o` come from the head entry and are held stable while `resp_valid_o` is high and not popped.
  - Responses are returned strictly in request order.
- **Simultaneous accept and pop.** Both happen and occupancy is unchanged. On an empty queue, accept and pop cannot coincide.
- **`flush_i`.** Effective only when `run_i` is high. Clears the queue (pointers and occupancy to 0) and has priority over both accept and pop. `resp_valid_o` and `req_ready_o` are not gated by `flush_i` combinationally, but no transfer is recorded.
- **`run_i` low.**
  - No accept, pop, countdown or flush.
  - `resp_valid_o = 0` and `req_ready_o = 0`.
  - Backing-array writes still occur.
- **Reset.**
  - Queue empty, all entry countdowns 0.
  - `req_ready_o` = `run_i`.
  - `resp_valid_o`, `resp_data_o`, `resp_tag_o`, `resp_index_o` and `outstanding_o` are all 0.
  - The backing array is not reset.
- **Reset mid-operation.** All in-flight requests are discarded with no response.

## Timing
- A request accepted at the edge ending cycle c has its response valid no earlier than cycle c+`MISS_PENALTY` (counted in `run_i`-high cycles).
  - It is later if older entries are still queued.
- **Back-to-back requests** with `resp_ready_i` held high give one response per cycle. The i-th response appears in cycle c0+`MISS_PENALTY`+i.
- **Full throughput requires `QUEUE_DEPTH ≥ MISS_PENALTY+1`.** Otherwise `req_ready_o` throttles.
- **Backpressure.** Entries behind a stalled head keep counting down. When the head is released they drain one per cycle with no extra penalty.
- **`outstanding_o`** is registered and reflects the post-edge occupancy.
- **Backing-array writes** are visible to accepts from the next cycle onward.

## Test plan
- **Single request.** Preload line 3 = `0xA5…A5` and hold `run_i`=1. Request `0x0000_0060` in cycle 10 → response valid in cycle 12 (`MISS_PENALTY`=2) with data `0xA5…A5`, tag 0, index 3, and `outstanding_o` back to 0 after the pop.
- **Back-to-back burst.** 6 requests (`0x0`, `0x20` … `0xA0`) with `QUEUE_DEPTH`=4 and `resp_ready_i`=1 → 6 in-order responses in consecutive cycles, and `req_ready_o` never drops.
- **Full queue.** Hold `resp_ready_i`=0 and issue 5 requests → 4 accepted, `req_ready_o`=0 on the 5th, head valid with stable data.
  - Then raise `resp_ready_i` → the 4 responses drain in 4 consecutive cycles, and the 5th is accepted in the first drain cycle or later.
- **`run_i`, `flush_i` and reset.**
  - Drop `run_i` for 3 cycles mid-countdown → response delayed by exactly 3 cycles.
  - Assert `flush_i` with 3 queued → no responses and occupancy 0.
  - Assert reset with 2 queued → outputs 0 and no responses.
- **Boundaries.**
  - Same-cycle write and accept to line 7 → response carries the old data.
  - Address `(1<<(MEM_LINES_LOG+OFFSET_BITS)) + 0x40` reads line 2, with the tag reflecting the full address.
  - `MISS_PENALTY`=1 build → response valid the cycle after the request.
